uart_tx_cfg: RTL

//  Parametrised successor to the fixed 8N1 UART transmitter. Serialises DATA_WIDTH-bit words
//  LSB-first with runtime baud divisor, parity mode and stop-bit count, using a valid/ready

---
 rtl/uart_tx_cfg.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_WIDTH bits LSB-first, runtime divisor, parity and stop count.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry word FIFO in front of the serialiser.
module uart_tx_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_WIDTH-1:0]  clks_per_bit,
    input  logic [1:0]            parity_mode,
    input  logic                  two_stop,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_done,
    output logic                  busy,
    output logic                  tx
);

    localparam int IDX_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                  state_q, state_n;
    logic [DIV_WIDTH-1:0]    cnt_q, cnt_n;
    logic [IDX_W-1:0]        idx_q, idx_n;
    logic                    stop_q, stop_n;
    logic                    tx_q, tx_n;
    logic [DATA_WIDTH-1:0]   data_q, data_n;
    logic [DIV_WIDTH-1:0]    n_q;
    logic                    par_en_q, par_en_n;
    logic                    par_odd_q, par_odd_n;
    logic                    two_stop_q;

    logic                    last_bit, frame_end, start_ok, take;
    logic                    src_avail;
    logic [DATA_WIDTH-1:0]   src_data;

    assign last_bit  = (cnt_q == n_q - DIV_WIDTH'(1));
    assign frame_end = (state_q == S_STOP) && last_bit && (stop_q == two_stop_q);
    assign start_ok  = (state_q == S_IDLE) || frame_end;
    assign take      = start_ok && src_avail;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_q, rd_q;
    logic                  full, empty, push;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push      = tx_valid && !full;
    assign tx_ready  = !full;
    assign src_avail = !empty;
    assign src_data  = mem[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + (AW+1)'(1);
            if (take) rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q[AW-1:0]] <= tx_data;
    end
`else
    assign tx_ready  = start_ok;
    assign src_avail = tx_valid;
    assign src_data  = tx_data;
`endif

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        idx_n     = idx_q;
        stop_n    = stop_q;
        data_n    = take ? src_data : data_q;
        par_en_n  = take ? (parity_mode == 2'b01 || parity_mode == 2'b10) : par_en_q;
        par_odd_n = take ? (parity_mode == 2'b10) : par_odd_q;

        case (state_q)
            S_IDLE: begin
                if (take) begin
                    state_n = S_START;
                    cnt_n   = '0;
                end
            end
            S_START: begin
                if (last_bit) begin
                    state_n = S_DATA;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else begin
                    cnt_n = cnt_q + DIV_WIDTH'(1);
                end
            end
            S_DATA: begin
                if (last_bit) begin
                    cnt_n = '0;
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_n = par_en_q ? S_PARITY : S_STOP;
                        stop_n  = 1'b0;
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt_q + DIV_WIDTH'(1);
                end
            end
            S_PARITY: begin
                if (last_bit) begin
                    state_n = S_STOP;
                    stop_n  = 1'b0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + DIV_WIDTH'(1);
                end
            end
            S_STOP: begin
                if (last_bit) begin
                    cnt_n = '0;
                    if (stop_q == two_stop_q) begin
                        state_n = take ? S_START : S_IDLE;
                    end else begin
                        stop_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_q + DIV_WIDTH'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        // The line level for the next cycle is decided here so tx comes straight from a flop.
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = data_n[idx_n];
            S_PARITY: tx_n = par_odd_n ? ~^data_n : ^data_n;
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            stop_q  <= stop_n;
            tx_q    <= tx_n;
        end
    end

    // Frame word and configuration are captured only when a word is taken.
    always_ff @(posedge clk) begin
        if (take) begin
            data_q     <= src_data;
            n_q        <= (clks_per_bit == '0) ? DIV_WIDTH'(1) : clks_per_bit;
            par_en_q   <= par_en_n;
            par_odd_q  <= par_odd_n;
            two_stop_q <= two_stop;
        end
    end

    assign tx      = tx_q;
    assign busy    = (state_q != S_IDLE);
    assign tx_done = frame_end;

endmodule
